// File: rtl/btb_way_array_if.sv
// BTB way-array bus: fetch lookup, branch update, PLRU handshake and results.
interface btb_way_array_if #(
    parameter int INDEX_W = 7,
    parameter int PC_W    = 32
);
    logic                BPU__Stall;
    logic                Flush;
    logic                Lookup_Valid;
    logic [PC_W-1:0]     Lookup_PC;
    logic                Update_Valid;
    logic [PC_W-1:0]     Update_PC;
    logic [PC_W-1:0]     Update_Target;
    logic [1:0]          LRU_Set;
    logic [INDEX_W-1:0]  BTB_Read_Addr__reg;
    logic                Read_Access;
    logic                BTB_Hit_Set0;
    logic                BTB_Hit_Set1;
    logic                BTB_Hit_Set2;
    logic                BTB_Hit_Set3;
    logic                Hit;
    logic [PC_W-1:0]     Pred_Target;
    logic [INDEX_W-1:0]  BTB_Write_Addr__reg;
    logic                Write_Access;

    // BPU / testbench side
    modport master (
        output BPU__Stall, Flush, Lookup_Valid, Lookup_PC,
               Update_Valid, Update_PC, Update_Target, LRU_Set,
        input  BTB_Read_Addr__reg, Read_Access,
               BTB_Hit_Set0, BTB_Hit_Set1, BTB_Hit_Set2, BTB_Hit_Set3,
               Hit, Pred_Target, BTB_Write_Addr__reg, Write_Access
    );

    // Way-array side
    modport slave (
        input  BPU__Stall, Flush, Lookup_Valid, Lookup_PC,
               Update_Valid, Update_PC, Update_Target, LRU_Set,
        output BTB_Read_Addr__reg, Read_Access,
               BTB_Hit_Set0, BTB_Hit_Set1, BTB_Hit_Set2, BTB_Hit_Set3,
               Hit, Pred_Target, BTB_Write_Addr__reg, Write_Access
    );
endinterface

// File: rtl/btb_way_array.sv
// 4-way set-associative BTB storage: registered-index lookup with per-way
// hits, in-place target refresh on tag match, PLRU-chosen allocation otherwise.
module btb_way_array #(
    parameter int INDEX_W = 7,
    parameter int PC_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    btb_way_array_if.slave    bus
);
    localparam int NSETS = 1 << INDEX_W;
    localparam int TAG_W = PC_W - INDEX_W - 2;
    localparam int TGT_W = PC_W - 2;

    // Only valid bits are reset; tag/target contents are don't-care when invalid.
    logic [NSETS-1:0][3:0] valid_q;
    logic [TAG_W-1:0]      tag_mem [NSETS][4];
    logic [TGT_W-1:0]      tgt_mem [NSETS][4];

    logic                  vld_p1;
    logic [INDEX_W-1:0]    lkp_idx_p1;
    logic [TAG_W-1:0]      lkp_tag_p1;
    logic                  upd_vld_p1;
    logic [INDEX_W-1:0]    upd_idx_p1;
    logic [TAG_W-1:0]      upd_tag_p1;
    logic [TGT_W-1:0]      upd_tgt_p1;

    logic [3:0]            hit_p2;
    logic [PC_W-1:0]       pred_p2;
    logic [3:0]            upd_match;
    logic [1:0]            match_way;
    logic [1:0]            wr_way;
    logic                  wr_en;

    // PC low bits are instruction alignment and carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.Lookup_PC[1:0], bus.Update_PC[1:0], bus.Update_Target[1:0]};

    // Stage 1 control: request valids, frozen by stall, killed by flush.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1     <= 1'b0;
            upd_vld_p1 <= 1'b0;
        end else if (bus.Flush) begin
            vld_p1     <= 1'b0;
            upd_vld_p1 <= 1'b0;
        end else if (!bus.BPU__Stall) begin
            vld_p1     <= bus.Lookup_Valid;
            upd_vld_p1 <= bus.Update_Valid;
        end
    end

    // Stage 1 data: lookup and update index/tag/target, held while stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lkp_idx_p1 <= '0;
            lkp_tag_p1 <= '0;
            upd_idx_p1 <= '0;
            upd_tag_p1 <= '0;
            upd_tgt_p1 <= '0;
        end else if (!bus.BPU__Stall) begin
            lkp_idx_p1 <= bus.Lookup_PC[INDEX_W+1:2];
            lkp_tag_p1 <= bus.Lookup_PC[PC_W-1:INDEX_W+2];
            upd_idx_p1 <= bus.Update_PC[INDEX_W+1:2];
            upd_tag_p1 <= bus.Update_PC[PC_W-1:INDEX_W+2];
            upd_tgt_p1 <= bus.Update_Target[PC_W-1:2];
        end
    end

    // Stage 2 lookup: per-way tag compare and hit-way target select (pre-write view).
    always_comb begin
        hit_p2  = '0;
        pred_p2 = '0;
        for (int w = 0; w < 4; w++) begin
            hit_p2[w] = vld_p1 & valid_q[lkp_idx_p1][w] & (tag_mem[lkp_idx_p1][w] == lkp_tag_p1);
            if (hit_p2[w]) pred_p2 = {tgt_mem[lkp_idx_p1][w], 2'b00};
        end
    end

    // Update way select: refresh a matching way in place, else take the PLRU victim.
    always_comb begin
        upd_match = '0;
        match_way = 2'd0;
        for (int w = 0; w < 4; w++) begin
            upd_match[w] = valid_q[upd_idx_p1][w] & (tag_mem[upd_idx_p1][w] == upd_tag_p1);
            if (upd_match[w]) match_way = w[1:0];
        end
    end

    assign wr_way = (|upd_match) ? match_way : bus.LRU_Set;
    assign wr_en  = upd_vld_p1 & ~bus.BPU__Stall & ~bus.Flush;

    // Valid bits: async clear on reset, sync clear on flush, set on write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (bus.Flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[upd_idx_p1][wr_way] <= 1'b1;
        end
    end

    // Tag/target storage write for the selected way.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[upd_idx_p1][wr_way] <= upd_tag_p1;
            tgt_mem[upd_idx_p1][wr_way] <= upd_tgt_p1;
        end
    end

    assign bus.BTB_Read_Addr__reg  = lkp_idx_p1;
    assign bus.Read_Access         = vld_p1;
    assign bus.BTB_Hit_Set0        = hit_p2[0];
    assign bus.BTB_Hit_Set1        = hit_p2[1];
    assign bus.BTB_Hit_Set2        = hit_p2[2];
    assign bus.BTB_Hit_Set3        = hit_p2[3];
    assign bus.Hit                 = |hit_p2;
    assign bus.Pred_Target         = pred_p2;
    assign bus.BTB_Write_Addr__reg = upd_idx_p1;
    assign bus.Write_Access        = upd_vld_p1 & ~(|upd_match);
endmodule

// File: tb/tb_btb_way_array.sv
// Directed testbench for btb_way_array: reset, allocate, refresh, eviction,
// stall freeze, flush and mid-update reset.
module tb_btb_way_array;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    btb_way_array_if #(.INDEX_W(7), .PC_W(32)) bus ();

    btb_way_array #(.INDEX_W(7), .PC_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.BPU__Stall    = 1'b0;
        bus.Flush         = 1'b0;
        bus.Lookup_Valid  = 1'b0;
        bus.Lookup_PC     = '0;
        bus.Update_Valid  = 1'b0;
        bus.Update_PC     = '0;
        bus.Update_Target = '0;
        bus.LRU_Set       = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        #1;
        n_checks++;
        if ({bus.Read_Access, bus.Write_Access, bus.Hit, bus.BTB_Hit_Set0, bus.BTB_Hit_Set1,
             bus.BTB_Hit_Set2, bus.BTB_Hit_Set3} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {bus.Read_Access, bus.Write_Access, bus.Hit});
        end
        n_checks++;
        if ({bus.Pred_Target, bus.BTB_Read_Addr__reg, bus.BTB_Write_Addr__reg} !== 46'b0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h expected 0", bus.Pred_Target,
                               bus.BTB_Read_Addr__reg, bus.BTB_Write_Addr__reg);
        end
        tick();
        RST = 1'b0;
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_1000;
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if ({bus.Read_Access, bus.Hit} !== 2'b10 || bus.Pred_Target !== 32'h0 || bus.BTB_Read_Addr__reg !== 7'h00) begin
            n_fail++; $display("FAIL first_lookup: got ra=%b hit=%b tgt=%h idx=%h expected ra=1 hit=0 tgt=0 idx=00",
                               bus.Read_Access, bus.Hit, bus.Pred_Target, bus.BTB_Read_Addr__reg);
        end
    endtask

    task automatic test_allocate();
        do_reset();
        bus.Update_Valid = 1'b1; bus.Update_PC = 32'h0000_1000; bus.Update_Target = 32'h0000_2000;
        tick();
        bus.Update_Valid = 1'b0; bus.LRU_Set = 2'd2;
        n_checks++;
        if (bus.Write_Access !== 1'b1 || bus.BTB_Write_Addr__reg !== 7'h00) begin
            n_fail++; $display("FAIL alloc_wa: got wa=%b idx=%h expected wa=1 idx=00", bus.Write_Access, bus.BTB_Write_Addr__reg);
        end
        tick();
        n_checks++;
        if (bus.Write_Access !== 1'b0) begin
            n_fail++; $display("FAIL alloc_wa_pulse: got %b expected 0", bus.Write_Access);
        end
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_1000;
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if ({bus.BTB_Hit_Set0, bus.BTB_Hit_Set1, bus.BTB_Hit_Set2, bus.BTB_Hit_Set3, bus.Hit} !== 5'b00101
            || bus.Pred_Target !== 32'h0000_2000) begin
            n_fail++; $display("FAIL alloc_hit: got hits=%b%b%b%b tgt=%h expected way2 tgt=00002000",
                               bus.BTB_Hit_Set0, bus.BTB_Hit_Set1, bus.BTB_Hit_Set2, bus.BTB_Hit_Set3, bus.Pred_Target);
        end
        tick();
        n_checks++;
        if (bus.Read_Access !== 1'b0 || bus.Hit !== 1'b0 || bus.Pred_Target !== 32'h0) begin
            n_fail++; $display("FAIL no_lookup_no_hit: got ra=%b hit=%b tgt=%h expected 0", bus.Read_Access, bus.Hit, bus.Pred_Target);
        end
    endtask

    // Continues on the state left by test_allocate; low target bits must be dropped.
    task automatic test_refresh();
        bus.Update_Valid = 1'b1; bus.Update_PC = 32'h0000_1000; bus.Update_Target = 32'h0000_3003;
        tick();
        bus.Update_Valid = 1'b0; bus.LRU_Set = 2'd0;
        n_checks++;
        if (bus.Write_Access !== 1'b0) begin
            n_fail++; $display("FAIL refresh_wa: got %b expected 0", bus.Write_Access);
        end
        tick();
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_1000;
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if ({bus.BTB_Hit_Set0, bus.BTB_Hit_Set1, bus.BTB_Hit_Set2, bus.BTB_Hit_Set3} !== 4'b0010
            || bus.Pred_Target !== 32'h0000_3000) begin
            n_fail++; $display("FAIL refresh_hit: got hits=%b%b%b%b tgt=%h expected way2 only tgt=00003000",
                               bus.BTB_Hit_Set0, bus.BTB_Hit_Set1, bus.BTB_Hit_Set2, bus.BTB_Hit_Set3, bus.Pred_Target);
        end
    endtask

    // Five back-to-back updates to set 0; the fifth evicts way 1 (0x200).
    task automatic test_back_to_back();
        logic [31:0] pcs [5];
        logic [1:0]  lru [5];
        pcs = '{32'h0, 32'h200, 32'h400, 32'h600, 32'h800};
        lru = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.Update_Valid = 1'b1; bus.Update_PC = pcs[i]; bus.Update_Target = 32'h0000_4000 + 32'(i * 16);
            tick();
            bus.LRU_Set = lru[i];
            n_checks++;
            if (bus.Write_Access !== 1'b1) begin
                n_fail++; $display("FAIL b2b_wa[%0d]: got %b expected 1", i, bus.Write_Access);
            end
        end
        bus.Update_Valid = 1'b0;
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h200;
        tick();
        n_checks++;
        if (bus.Hit !== 1'b0) begin
            n_fail++; $display("FAIL evicted_miss: got hit=%b expected 0", bus.Hit);
        end
        bus.Lookup_PC = 32'h800;
        tick();
        n_checks++;
        if ({bus.BTB_Hit_Set0, bus.BTB_Hit_Set1, bus.BTB_Hit_Set2, bus.BTB_Hit_Set3} !== 4'b0100
            || bus.Pred_Target !== 32'h0000_4040) begin
            n_fail++; $display("FAIL new_way1_hit: got hits=%b%b%b%b tgt=%h expected way1 tgt=00004040",
                               bus.BTB_Hit_Set0, bus.BTB_Hit_Set1, bus.BTB_Hit_Set2, bus.BTB_Hit_Set3, bus.Pred_Target);
        end
        bus.Lookup_PC = 32'h600;
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if (bus.BTB_Hit_Set3 !== 1'b1 || bus.Pred_Target !== 32'h0000_4030) begin
            n_fail++; $display("FAIL kept_way3_hit: got h3=%b tgt=%h expected 1 tgt=00004030", bus.BTB_Hit_Set3, bus.Pred_Target);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.Update_Valid = 1'b1; bus.Update_PC = 32'h0000_1010; bus.Update_Target = 32'h0000_5000;
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_1010;
        tick();
        bus.LRU_Set = 2'd0;
        bus.BPU__Stall = 1'b1;
        bus.Update_PC = 32'h0000_1020; bus.Lookup_PC = 32'h0000_1020;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({bus.Read_Access, bus.Write_Access, bus.Hit} !== 3'b110
                || bus.BTB_Read_Addr__reg !== 7'h04 || bus.BTB_Write_Addr__reg !== 7'h04) begin
                n_fail++; $display("FAIL stall_freeze[%0d]: got ra=%b wa=%b hit=%b ridx=%h widx=%h expected 1 1 0 04 04",
                                   c, bus.Read_Access, bus.Write_Access, bus.Hit, bus.BTB_Read_Addr__reg, bus.BTB_Write_Addr__reg);
            end
        end
        idle();
        tick();
        n_checks++;
        if (bus.Write_Access !== 1'b0 || bus.Read_Access !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got wa=%b ra=%b expected 0 0", bus.Write_Access, bus.Read_Access);
        end
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_1010;
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if (bus.BTB_Hit_Set0 !== 1'b1 || bus.Pred_Target !== 32'h0000_5000) begin
            n_fail++; $display("FAIL stall_write_after: got h0=%b tgt=%h expected 1 tgt=00005000", bus.BTB_Hit_Set0, bus.Pred_Target);
        end
        bus.Lookup_PC = 32'h0000_1020;
        bus.Lookup_Valid = 1'b1;
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if (bus.Hit !== 1'b0) begin
            n_fail++; $display("FAIL stall_dropped_update: got hit=%b expected 0", bus.Hit);
        end
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        bus.Update_Valid = 1'b1; bus.Update_PC = 32'h0000_1000; bus.Update_Target = 32'h0000_6000;
        tick();
        bus.LRU_Set = 2'd0;
        bus.Update_PC = 32'h0000_1004; bus.Update_Target = 32'h0000_7000;
        tick();
        bus.LRU_Set = 2'd3;
        bus.Update_Valid = 1'b0;
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_1000;
        tick();
        n_checks++;
        if (bus.BTB_Hit_Set0 !== 1'b1 || bus.Pred_Target !== 32'h0000_6000) begin
            n_fail++; $display("FAIL prefill_hit: got h0=%b tgt=%h expected 1 tgt=00006000", bus.BTB_Hit_Set0, bus.Pred_Target);
        end
        bus.Lookup_Valid = 1'b0;
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        n_checks++;
        if (bus.Read_Access !== 1'b0 || bus.Write_Access !== 1'b0) begin
            n_fail++; $display("FAIL flush_ctrl: got ra=%b wa=%b expected 0 0", bus.Read_Access, bus.Write_Access);
        end
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_1000;
        tick();
        bus.Lookup_PC = 32'h0000_1004;
        n_checks++;
        if (bus.Read_Access !== 1'b1 || bus.Hit !== 1'b0) begin
            n_fail++; $display("FAIL flush_miss_set0: got ra=%b hit=%b expected 1 0", bus.Read_Access, bus.Hit);
        end
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if (bus.Hit !== 1'b0) begin
            n_fail++; $display("FAIL flush_miss_set1: got hit=%b expected 0", bus.Hit);
        end
        // Reset arrives while an allocating update is pending.
        bus.Update_Valid = 1'b1; bus.Update_PC = 32'h0000_2000; bus.Update_Target = 32'h0000_8000;
        tick();
        bus.Update_Valid = 1'b0; bus.LRU_Set = 2'd1;
        n_checks++;
        if (bus.Write_Access !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pending: got wa=%b expected 1", bus.Write_Access);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if (bus.Write_Access !== 1'b0) begin
            n_fail++; $display("FAIL midreset_async: got wa=%b expected 0", bus.Write_Access);
        end
        tick();
        RST = 1'b0;
        bus.Lookup_Valid = 1'b1; bus.Lookup_PC = 32'h0000_2000;
        tick();
        bus.Lookup_Valid = 1'b0;
        n_checks++;
        if (bus.Read_Access !== 1'b1 || bus.Hit !== 1'b0) begin
            n_fail++; $display("FAIL midreset_absent: got ra=%b hit=%b expected 1 0", bus.Read_Access, bus.Hit);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        idle();
        test_reset();
        test_allocate();
        test_refresh();
        test_back_to_back();
        test_stall();
        test_flush_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_way_array.md
Name: btb_way_array

Overview:
4-way set-associative Branch Target Buffer storage (tags, targets, valid bits) for the BPU. It performs a registered-index lookup and produces per-way hit signals and the predicted target. It drives the read-side and write-side access strobes of the BTB pseudo-LRU tracker. On allocation it consumes that tracker's victim-way output (LRU_Set) to choose which way to overwrite.

Parameters:
INDEX_W, 7, set index width (2^INDEX_W = 128 sets); index = PC[INDEX_W+1:2]
PC_W, 32, PC and target width; tag = PC[PC_W-1:INDEX_W+2] (23 bits at defaults)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
BPU__Stall  in  1  freeze all pipeline registers and array writes
Flush  in  1  invalidate all entries
Lookup_Valid  in  1  fetch lookup request
Lookup_PC  in  PC_W  fetch PC
Update_Valid  in  1  resolved taken branch to record
Update_PC  in  PC_W  branch PC
Update_Target  in  PC_W  branch target (bits [1:0] ignored)
LRU_Set  in  2  victim way from the PLRU for BTB_Write_Addr__reg
BTB_Read_Addr__reg  out  INDEX_W  registered lookup index
Read_Access  out  1  registered lookup valid
BTB_Hit_Set0..3  out  1 each  per-way hit, stage 2
Hit  out  1  OR of the four hit signals
Pred_Target  out  PC_W  target of the hit way, {stored,2'b00}; 0 on miss
BTB_Write_Addr__reg  out  INDEX_W  registered update index
Write_Access  out  1  registered update that allocates a new way

Behaviour:
- Storage: per set and way, valid (1b), tag, target (PC_W-2 bits). Only the valid bits are reset. Tag and target arrays have no reset.
- Async RST: all valid=0. Lookup/update pipeline registers = 0. Hence Read_Access=0, Write_Access=0, all hits=0, Hit=0, Pred_Target=0, both address outputs=0.
- Stage 1 (posedge, ~BPU__Stall): register the lookup index, lookup tag, and Read_Access<=Lookup_Valid. Register the update index, tag, and target, and upd_v<=Update_Valid.
- Stage 2 (combinational on registered values):
  - BTB_Hit_SetN = Read_Access & valid[idx][N] & (tag[idx][N]==reg_tag).
  - Lookup latency is 1 cycle from Lookup_Valid to hit/target.
- Update way select (combinational on registered update):
  - Match = valid & tag equal in some way of BTB_Write_Addr__reg. If so, that way is overwritten in place (target refresh) and Write_Access=0.
  - Otherwise Write_Access=upd_v and the way LRU_Set is allocated.
  - Tags are never duplicated within a set, so at most one hit per lookup.
- Array write at posedge when upd_v & ~BPU__Stall & ~Flush: write tag, target, and valid=1 into the selected way.
- BPU__Stall=1: all registers hold, so outputs stay stable. No array write. New Lookup_Valid/Update_Valid are dropped (the caller holds them).
- Flush=1 (sync, not gated by stall): all valid<=0 next edge. The pending update is discarded, Read_Access<=0, upd_v<=0.
- Same-cycle write and lookup to the same set: no bypass. Stage-2 hits reflect pre-write contents; the new entry is visible to the next lookup.
- Write_Access and LRU_Set refer to the same registered set in the same cycle. The PLRU advances on that edge.
- Reset mid-operation: an in-flight update is lost and no partial write occurs, because valid clears asynchronously.

Test Plan:
1. Reset, then lookup PC 0x0000_1000 -> next cycle Read_Access=1, Hit=0, Pred_Target=0, BTB_Read_Addr__reg=0x00.
2. Update PC 0x0000_1000 with target 0x0000_2000, LRU_Set=2 -> Write_Access=1 for one cycle, way 2 written. Lookup 0x0000_1000 two cycles later -> BTB_Hit_Set2=1, Pred_Target=0x0000_2000.
3. Re-update PC 0x0000_1000 with target 0x0000_3000 -> Write_Access=0, way 2 refreshed. Next lookup returns 0x0000_3000 with no other way hit.
4. Five PCs sharing index 0 (0x0000_0000, 0x200, 0x400, 0x600, 0x800) with LRU_Set driven 0,1,2,3,1 -> the fifth update evicts 0x200. Lookup 0x200 misses; lookup 0x800 gives BTB_Hit_Set1=1.
5. Hold BPU__Stall=1 for 3 cycles with an update pending -> outputs frozen and no array write. Release -> the write occurs on the first unstalled edge.
6. Fill two sets, pulse Flush -> all subsequent lookups miss. Separately, assert RST mid-update -> Write_Access=0 immediately and the entry is absent afterwards.
